// File: rtl/cache_mem_arb_pkg.sv
// ============================================================================
// Module : cache_mem_arb_pkg
// Brief  : Shared types and defaults for the I$/D$ main-memory arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_mem_arb_pkg;

  // Default geometry of the shared memory port
  localparam int DEF_ADDR_BITS = 28;
  localparam int DEF_DATA_BITS = 128;
  localparam int DEF_BEATS     = 4;

  // Arbiter transaction state
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WDATA = 2'd2,
    RRESP = 2'd3
  } state_t;

  // Owner encoding: one bit, the cache currently holding the memory port
  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/cache_mem_arbiter_arb_select.sv
// ============================================================================
// Module : arb_select
// Brief  : Combinational two-requester selector (I$ vs D$).
//          Build option ARB_ROUND_ROBIN_EN: simultaneous requests go to the
//          cache not granted last; otherwise D$ has fixed priority.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_select
  import cache_mem_arb_pkg::*;
(
  input  logic ic_req,
  input  logic dc_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  assign grant_valid = ic_req | dc_req;

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin pick: a lone requester always wins, a tie flips from last grant
  always_comb begin
    grant = OWNER_DC;
    if (ic_req && dc_req) begin
      grant = ~last_grant;
    end else if (ic_req) begin
      grant = OWNER_IC;
    end
  end
`else
  // Last grant is irrelevant with fixed priority
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Fixed priority pick: D$ wins any tie
  always_comb begin
    grant = OWNER_DC;
    if (ic_req && !dc_req) begin
      grant = OWNER_IC;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
// Module : cache_mem_arbiter
// Brief  : Shares the single main-memory port between I$ and D$. One cache
//          owns the port per transaction (request, write beats, read beats);
//          the arbiter returns to IDLE after the last beat.
//          Build option ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_mem_arbiter
  import cache_mem_arb_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int BEATS     = DEF_BEATS
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   ic_mem_req_valid,
  output logic                   ic_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
  input  logic                   ic_mem_req_rw,
  input  logic                   ic_mem_req_data_valid,
  output logic                   ic_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
  output logic                   ic_mem_resp_valid,
  output logic [DATA_BITS-1:0]   ic_mem_resp_data,

  input  logic                   dc_mem_req_valid,
  output logic                   dc_mem_req_ready,
  input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
  input  logic                   dc_mem_req_rw,
  input  logic                   dc_mem_req_data_valid,
  output logic                   dc_mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
  output logic                   dc_mem_resp_valid,
  output logic [DATA_BITS-1:0]   dc_mem_resp_data,

  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic                   mem_req_rw,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [DATA_BITS-1:0]   mem_resp_data
);

  localparam int                  CNT_BITS  = $clog2(BEATS);
  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

  state_t              state;
  state_t              state_next;
  logic                owner;
  logic [CNT_BITS-1:0] beat_cnt;
  logic                last_grant;
  logic                grant_valid;
  logic                grant;

  logic                req_fire;
  logic                wdata_fire;
  logic                resp_beat;
  logic                beat_last;

  arb_select u_arb_select (
    .ic_req      (ic_mem_req_valid),
    .dc_req      (dc_mem_req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last;

  // Remember who was granted most recently for round-robin tie breaking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_last <= OWNER_IC;
    end else if (state == IDLE && grant_valid) begin
      rr_last <= grant;
    end
  end

  assign last_grant = rr_last;
`else
  assign last_grant = OWNER_IC;
`endif

  // Handshake events of the current transaction phase
  assign req_fire   = (state == REQ)   && mem_req_valid && mem_req_ready;
  assign wdata_fire = (state == WDATA) && mem_req_data_valid && mem_req_data_ready;
  assign resp_beat  = (state == RRESP) && mem_resp_valid;
  assign beat_last  = (beat_cnt == LAST_BEAT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: arbitrate, issue request, then move data beats
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = REQ;
      REQ:     if (req_fire) state_next = mem_req_rw ? WDATA : RRESP;
      WDATA:   if (wdata_fire && beat_last) state_next = IDLE;
      RRESP:   if (resp_beat && beat_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the arbitration winner for the whole transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= OWNER_DC;
    end else if (state == IDLE && grant_valid) begin
      owner <= grant;
    end
  end

  // Beat counter: cleared when the request is accepted, wraps at completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt <= '0;
    end else if (req_fire) begin
      beat_cnt <= '0;
    end else if (wdata_fire || resp_beat) begin
      beat_cnt <= beat_last ? '0 : beat_cnt + CNT_BITS'(1);
    end
  end

  // Output routing: only the owner is connected, and only in its phase
  always_comb begin
    mem_req_valid         = 1'b0;
    mem_req_addr          = '0;
    mem_req_rw            = 1'b0;
    mem_req_data_valid    = 1'b0;
    mem_req_data_bits     = '0;
    mem_req_data_mask     = '0;
    ic_mem_req_ready      = 1'b0;
    dc_mem_req_ready      = 1'b0;
    ic_mem_req_data_ready = 1'b0;
    dc_mem_req_data_ready = 1'b0;
    ic_mem_resp_valid     = 1'b0;
    dc_mem_resp_valid     = 1'b0;
    ic_mem_resp_data      = '0;
    dc_mem_resp_data      = '0;
    case (state)
      REQ: begin
        if (owner == OWNER_DC) begin
          mem_req_valid    = dc_mem_req_valid;
          mem_req_addr     = dc_mem_req_addr;
          mem_req_rw       = dc_mem_req_rw;
          dc_mem_req_ready = mem_req_ready;
        end else begin
          mem_req_valid    = ic_mem_req_valid;
          mem_req_addr     = ic_mem_req_addr;
          mem_req_rw       = ic_mem_req_rw;
          ic_mem_req_ready = mem_req_ready;
        end
      end
      WDATA: begin
        if (owner == OWNER_DC) begin
          mem_req_data_valid    = dc_mem_req_data_valid;
          mem_req_data_bits     = dc_mem_req_data_bits;
          mem_req_data_mask     = dc_mem_req_data_mask;
          dc_mem_req_data_ready = mem_req_data_ready;
        end else begin
          mem_req_data_valid    = ic_mem_req_data_valid;
          mem_req_data_bits     = ic_mem_req_data_bits;
          mem_req_data_mask     = ic_mem_req_data_mask;
          ic_mem_req_data_ready = mem_req_data_ready;
        end
      end
      RRESP: begin
        ic_mem_resp_data = mem_resp_data;
        dc_mem_resp_data = mem_resp_data;
        if (owner == OWNER_DC) begin
          dc_mem_resp_valid = mem_resp_valid;
        end else begin
          ic_mem_resp_valid = mem_resp_valid;
        end
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  // Flag read beats the memory delivers while no read response is expected
  always_ff @(posedge clk) begin
    if (reset && mem_resp_valid) begin
      assert (state == RRESP)
        else $warning("cache_mem_arbiter: memory response beat dropped outside RRESP");
    end
  end
`endif

endmodule

`default_nettype wire
